// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader and the instruction memory
// it fills.
//
// Contents:
//   DEFAULT_DATA_WIDTH - default size of the target byte memory, in bytes
//   state_t            - loader FSM state encoding
//   burst_fits         - checks that a burst of 16-bit words starting at a
//                        byte address stays inside the memory
package instruction_loader_pkg;

   localparam int DEFAULT_DATA_WIDTH = 256;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_WORD = 2'd1,
      ST_WRITE_HI  = 2'd2,
      ST_WRITE_LO  = 2'd3
   } state_t;

   // The end address is computed in 17 bits so that a burst running past
   // 0xFFFF is seen as oversized instead of wrapping back to a small
   // address that would look legal.
   function automatic logic burst_fits(input logic [15:0] base,
                                       input logic [7:0]  count,
                                       input logic [16:0] limit);
      logic [16:0] end_addr;
      end_addr = {1'b0, base} + {8'd0, count, 1'b0};
      return end_addr <= limit;
   endfunction

endpackage

// File: rtl/instruction_loader.sv
// Instruction loader: takes a stream of 16-bit instruction words and writes
// them, big-endian, into a byte-wide instruction memory starting at a given
// base address.
//
// Ports:
//   i_Clk              - clock, all state changes on rising edge
//   i_Reset            - asynchronous active-high reset
//   i_Start            - begin a burst (only looked at while idle)
//   i_Base_Address     - first byte address of the burst
//   i_Count            - number of 16-bit words in the burst
//   i_Instruction      - incoming instruction word
//   i_Valid            - i_Instruction is valid
//   o_Ready            - a word is accepted this cycle
//   o_Mem_Write_Enable - byte write strobe
//   o_Mem_Address      - byte address of the write
//   o_Mem_Write_Data   - byte to write
//   o_Busy             - burst in progress
//   o_Done             - one-cycle pulse at the end of every burst
//   o_Error            - sticky flag, last start request was rejected
module instruction_loader
   import instruction_loader_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic        i_Clk,
   input  logic        i_Reset,
   input  logic        i_Start,
   input  logic [15:0] i_Base_Address,
   input  logic [7:0]  i_Count,
   input  logic [15:0] i_Instruction,
   input  logic        i_Valid,
   output logic        o_Ready,
   output logic        o_Mem_Write_Enable,
   output logic [15:0] o_Mem_Address,
   output logic [7:0]  o_Mem_Write_Data,
   output logic        o_Busy,
   output logic        o_Done,
   output logic        o_Error
);

   localparam logic [16:0] LIMIT = 17'(DATA_WIDTH);

   state_t      state;
   state_t      next_state;
   logic [15:0] pointer;
   logic [7:0]  remaining;
   logic [15:0] instr;
   logic        done_reg;
   logic        error_reg;
   logic        start_zero;
   logic        start_reject;

   // An empty burst completes immediately; a misaligned or oversized one
   // is refused. An empty burst is never flagged as an error, even with an
   // odd base, because nothing would be written.
   assign start_zero   = (i_Count == 8'd0);
   assign start_reject = i_Base_Address[0] ||
                         !burst_fits(i_Base_Address, i_Count, LIMIT);

   // State register
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: one word takes WAIT_WORD, WRITE_HI, WRITE_LO, so a
   // continuously valid source gets one word every three cycles.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (i_Start && !start_zero && !start_reject) begin
               next_state = ST_WAIT_WORD;
            end
         end
         ST_WAIT_WORD: begin
            if (i_Valid) begin
               next_state = ST_WRITE_HI;
            end
         end
         ST_WRITE_HI: begin
            next_state = ST_WRITE_LO;
         end
         ST_WRITE_LO: begin
            if (remaining == 8'd1) begin
               next_state = ST_IDLE;
            end else begin
               next_state = ST_WAIT_WORD;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Burst bookkeeping. The done flag is registered so that it lands in the
   // first cycle after the event that ends the burst (start decision or the
   // last low-byte write), and is cleared by default every other cycle.
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         pointer   <= 16'd0;
         remaining <= 8'd0;
         instr     <= 16'd0;
         done_reg  <= 1'b0;
         error_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_Start) begin
                  if (start_zero) begin
                     done_reg  <= 1'b1;
                     error_reg <= 1'b0;
                  end else if (start_reject) begin
                     done_reg  <= 1'b1;
                     error_reg <= 1'b1;
                  end else begin
                     pointer   <= i_Base_Address;
                     remaining <= i_Count;
                     error_reg <= 1'b0;
                  end
               end
            end
            ST_WAIT_WORD: begin
               if (i_Valid) begin
                  instr <= i_Instruction;
               end
            end
            ST_WRITE_LO: begin
               pointer   <= pointer + 16'd2;
               remaining <= remaining - 8'd1;
               if (remaining == 8'd1) begin
                  done_reg <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs decoded from state and registers only. The high byte goes to
   // the lower address so {mem[a], mem[a+1]} reads the word back.
   always_comb begin
      o_Ready            = 1'b0;
      o_Mem_Write_Enable = 1'b0;
      o_Mem_Address      = 16'd0;
      o_Mem_Write_Data   = 8'd0;
      o_Busy             = (state != ST_IDLE);
      o_Done             = done_reg;
      o_Error            = error_reg;
      case (state)
         ST_WAIT_WORD: begin
            o_Ready = 1'b1;
         end
         ST_WRITE_HI: begin
            o_Mem_Write_Enable = 1'b1;
            o_Mem_Address      = pointer;
            o_Mem_Write_Data   = instr[15:8];
         end
         ST_WRITE_LO: begin
            o_Mem_Write_Enable = 1'b1;
            o_Mem_Address      = pointer + 16'd1;
            o_Mem_Write_Data   = instr[7:0];
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_instruction_loader.sv
// Testbench for instruction_loader: table of start requests checked for
// accept/reject/empty behaviour, a write scoreboard fed as words are driven,
// plus hand sequences for throughput and reset in the middle of a burst.
module tb_instruction_loader;
   import instruction_loader_pkg::*;

   localparam int K_ACCEPT = 0;
   localparam int K_ZERO   = 1;
   localparam int K_REJECT = 2;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_t;

   typedef struct {
      logic [15:0] base;
      logic [7:0]  count;
      int          kind;
      logic [15:0] w0;
      logic [15:0] w1;
   } vec_t;

   logic        i_Clk;
   logic        i_Reset;
   logic        i_Start;
   logic [15:0] i_Base_Address;
   logic [7:0]  i_Count;
   logic [15:0] i_Instruction;
   logic        i_Valid;
   logic        o_Ready;
   logic        o_Mem_Write_Enable;
   logic [15:0] o_Mem_Address;
   logic [7:0]  o_Mem_Write_Data;
   logic        o_Busy;
   logic        o_Done;
   logic        o_Error;

   int  total;
   int  bad;
   wr_t exp_q[$];
   vec_t vecs[10];

   instruction_loader #(.DATA_WIDTH(256)) dut (
      .i_Clk              (i_Clk),
      .i_Reset            (i_Reset),
      .i_Start            (i_Start),
      .i_Base_Address     (i_Base_Address),
      .i_Count            (i_Count),
      .i_Instruction      (i_Instruction),
      .i_Valid            (i_Valid),
      .o_Ready            (o_Ready),
      .o_Mem_Write_Enable (o_Mem_Write_Enable),
      .o_Mem_Address      (o_Mem_Address),
      .o_Mem_Write_Data   (o_Mem_Write_Data),
      .o_Busy             (o_Busy),
      .o_Done             (o_Done),
      .o_Error            (o_Error)
   );

   initial begin
      i_Clk = 1'b0;
      forever #5 i_Clk = ~i_Clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h required 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Every write strobe seen must match the oldest expected write.
   always @(negedge i_Clk) begin
      if (o_Mem_Write_Enable === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h required no write",
                     o_Mem_Address, o_Mem_Write_Data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            checkOutput("wr_addr", 32'(o_Mem_Address), 32'(e.addr));
            checkOutput("wr_data", 32'(o_Mem_Write_Data), 32'(e.data));
         end
      end
   end

   function automatic vec_t mkVec(input logic [15:0] base, input logic [7:0] count,
                                  input int kind, input logic [15:0] w0,
                                  input logic [15:0] w1);
      vec_t v;
      v.base  = base;
      v.count = count;
      v.kind  = kind;
      v.w0    = w0;
      v.w1    = w1;
      return v;
   endfunction

   function automatic logic [15:0] wordOf(input vec_t v, input int i);
      if (i == 0) return v.w0;
      if (i == 1) return v.w1;
      return v.w0 ^ {8'(i), ~8'(i)};
   endfunction

   task automatic pushWord(input logic [15:0] addr, input logic [15:0] w);
      exp_q.push_back('{addr: addr, data: w[15:8]});
      exp_q.push_back('{addr: addr + 16'd1, data: w[7:0]});
   endtask

   task automatic applyStimulus(input vec_t v);
      logic [15:0] ptr;
      logic        exp_err;
      int          waited;
      @(negedge i_Clk);
      i_Start        = 1'b1;
      i_Base_Address = v.base;
      i_Count        = v.count;
      @(negedge i_Clk);
      i_Start = 1'b0;
      if (v.kind != K_ACCEPT) begin
         exp_err = (v.kind == K_REJECT);
         checkOutput("nostart_done", 32'(o_Done), 32'd1);
         checkOutput("nostart_error", 32'(o_Error), 32'(exp_err));
         checkOutput("nostart_busy", 32'(o_Busy), 32'd0);
         @(negedge i_Clk);
         checkOutput("nostart_done_clear", 32'(o_Done), 32'd0);
         checkOutput("nostart_error_sticky", 32'(o_Error), 32'(exp_err));
         checkOutput("nostart_busy_low", 32'(o_Busy), 32'd0);
         return;
      end
      checkOutput("accept_busy", 32'(o_Busy), 32'd1);
      checkOutput("accept_error", 32'(o_Error), 32'd0);
      checkOutput("accept_done", 32'(o_Done), 32'd0);
      ptr = v.base;
      for (int i = 0; i < int'(v.count); i++) begin
         waited = 0;
         while (o_Ready !== 1'b1 && waited < 8) begin
            @(negedge i_Clk);
            waited++;
         end
         if (o_Ready !== 1'b1) begin
            checkOutput("ready_timeout", 32'(o_Ready), 32'd1);
            return;
         end
         i_Valid       = 1'b1;
         i_Instruction = wordOf(v, i);
         pushWord(ptr, i_Instruction);
         ptr = ptr + 16'd2;
         @(negedge i_Clk);
         i_Valid = 1'b0;
         checkOutput("write_hi_ready", 32'(o_Ready), 32'd0);
         @(negedge i_Clk);
         @(negedge i_Clk);
      end
      checkOutput("burst_done", 32'(o_Done), 32'd1);
      checkOutput("burst_idle", 32'(o_Busy), 32'd0);
      @(negedge i_Clk);
      checkOutput("burst_done_clear", 32'(o_Done), 32'd0);
      checkOutput("burst_writes_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      total          = 0;
      bad            = 0;
      i_Reset        = 1'b1;
      i_Start        = 1'b0;
      i_Base_Address = 16'd0;
      i_Count        = 8'd0;
      i_Instruction  = 16'd0;
      i_Valid        = 1'b0;

      vecs[0] = mkVec(16'h0000, 8'd2,   K_ACCEPT, 16'h1234, 16'hABCD);
      vecs[1] = mkVec(16'h0000, 8'd0,   K_ZERO,   16'h0000, 16'h0000);
      vecs[2] = mkVec(16'h0001, 8'd1,   K_REJECT, 16'h0000, 16'h0000);
      vecs[3] = mkVec(16'h0040, 8'd1,   K_ACCEPT, 16'h5AA5, 16'h0000);
      vecs[4] = mkVec(16'h00FE, 8'd1,   K_ACCEPT, 16'hF00D, 16'h0000);
      vecs[5] = mkVec(16'h00FE, 8'd2,   K_REJECT, 16'h0000, 16'h0000);
      vecs[6] = mkVec(16'h0003, 8'd0,   K_ZERO,   16'h0000, 16'h0000);
      vecs[7] = mkVec(16'h0000, 8'd128, K_ACCEPT, 16'h0F1E, 16'h2D3C);
      vecs[8] = mkVec(16'h0000, 8'd129, K_REJECT, 16'h0000, 16'h0000);
      vecs[9] = mkVec(16'hFFFE, 8'd1,   K_REJECT, 16'h0000, 16'h0000);

      repeat (2) @(negedge i_Clk);
      checkOutput("reset_ready", 32'(o_Ready), 32'd0);
      checkOutput("reset_we", 32'(o_Mem_Write_Enable), 32'd0);
      checkOutput("reset_busy", 32'(o_Busy), 32'd0);
      checkOutput("reset_done", 32'(o_Done), 32'd0);
      checkOutput("reset_error", 32'(o_Error), 32'd0);
      i_Reset = 1'b0;

      for (int n = 0; n < 10; n++) begin
         applyStimulus(vecs[n]);
      end

      // Throughput: with i_Valid held high, ready every third cycle.
      @(negedge i_Clk);
      i_Start        = 1'b1;
      i_Base_Address = 16'h0020;
      i_Count        = 8'd3;
      @(negedge i_Clk);
      i_Start = 1'b0;
      i_Valid = 1'b1;
      for (int k = 0; k < 9; k++) begin
         checkOutput("tput_ready", 32'(o_Ready), 32'((k % 3) == 0));
         if ((k % 3) == 0 && o_Ready === 1'b1) begin
            i_Instruction = 16'h7100 + 16'(k);
            pushWord(16'h0020 + 16'(2 * (k / 3)), i_Instruction);
         end
         @(negedge i_Clk);
      end
      i_Valid = 1'b0;
      checkOutput("tput_done", 32'(o_Done), 32'd1);
      checkOutput("tput_drained", 32'(exp_q.size()), 32'd0);

      // Stalled source, then reset right after the high byte of word 2.
      @(negedge i_Clk);
      i_Start        = 1'b1;
      i_Base_Address = 16'h0010;
      i_Count        = 8'd3;
      @(negedge i_Clk);
      i_Start       = 1'b0;
      i_Valid       = 1'b1;
      i_Instruction = 16'hC0DE;
      pushWord(16'h0010, 16'hC0DE);
      @(negedge i_Clk);
      i_Valid = 1'b0;
      @(negedge i_Clk);
      @(negedge i_Clk);
      for (int k = 0; k < 5; k++) begin
         checkOutput("stall_ready", 32'(o_Ready), 32'd1);
         checkOutput("stall_we", 32'(o_Mem_Write_Enable), 32'd0);
         @(negedge i_Clk);
      end
      i_Valid       = 1'b1;
      i_Instruction = 16'hBEEF;
      exp_q.push_back('{addr: 16'h0012, data: 8'hBE});
      @(negedge i_Clk);
      i_Valid = 1'b0;
      #1;
      i_Reset = 1'b1;
      #1;
      checkOutput("midrst_ready", 32'(o_Ready), 32'd0);
      checkOutput("midrst_we", 32'(o_Mem_Write_Enable), 32'd0);
      checkOutput("midrst_addr", 32'(o_Mem_Address), 32'd0);
      checkOutput("midrst_data", 32'(o_Mem_Write_Data), 32'd0);
      checkOutput("midrst_busy", 32'(o_Busy), 32'd0);
      checkOutput("midrst_done", 32'(o_Done), 32'd0);
      checkOutput("midrst_error", 32'(o_Error), 32'd0);
      @(negedge i_Clk);
      i_Reset = 1'b0;
      checkOutput("midrst_drained", 32'(exp_q.size()), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge i_Clk);
         checkOutput("postrst_busy", 32'(o_Busy), 32'd0);
         checkOutput("postrst_done", 32'(o_Done), 32'd0);
      end

      // Loader is back in IDLE and takes a fresh burst.
      applyStimulus(mkVec(16'h0080, 8'd2, K_ACCEPT, 16'h1357, 16'h2468));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
